// File: rtl/ram_pkg.sv
// Shared sizes and FSM state encoding for the RAM sweep master and its RAM model.
package ram_pkg;

   localparam int unsigned DEPTH_DEF = 12;
   localparam int unsigned W_DEF     = 8;
   localparam int unsigned SUM_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/ram_sweep_master.sv
// Sweeps a RAM window: reads each word, writes back word+addend, and tracks
// the sum and maximum of the original words.
module ram_sweep_master
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     base,
   input  logic [W-1:0]     len,
   input  logic [W-1:0]     addend,
   output logic [W-1:0]     Dir,
   output logic [W-1:0]     Dato_e,
   output logic             EN,
   input  logic [W-1:0]     Dato_s,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [SUM_W-1:0] suma,
   output logic [W-1:0]     maximo
);

   localparam int unsigned AW = W + 1;

   state_t             state_q, state_d;
   logic [W-1:0]       dir_q, dir_d;
   logic [W-1:0]       dato_e_q, dato_e_d;
   logic [W-1:0]       rem_q, rem_d;
   logic [W-1:0]       addend_q, addend_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [SUM_W-1:0]   suma_q, suma_d;
   logic [W-1:0]       maximo_q, maximo_d;
   logic [AW-1:0]      end_addr_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dir_q    <= '0;
         dato_e_q <= '0;
         rem_q    <= '0;
         addend_q <= '0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         suma_q   <= '0;
         maximo_q <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         dato_e_q <= dato_e_d;
         rem_q    <= rem_d;
         addend_q <= addend_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         suma_q   <= suma_d;
         maximo_q <= maximo_d;
      end
   end

   // Range check at one extra bit so base+len cannot wrap past DEPTH.
   always_comb begin
      end_addr_c = {1'b0, base} + {1'b0, len};
   end

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      dato_e_d = dato_e_q;
      rem_d    = rem_q;
      addend_d = addend_q;
      en_d     = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      suma_d   = suma_q;
      maximo_d = maximo_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  suma_d   = '0;
                  maximo_d = '0;
                  done_d   = 1'b1;
                  state_d  = FIN;
               end else if (end_addr_c > AW'(DEPTH)) begin
                  err_d = 1'b1;
               end else begin
                  dir_d    = base;
                  rem_d    = len;
                  addend_d = addend;
                  suma_d   = '0;
                  maximo_d = '0;
                  busy_d   = 1'b1;
                  state_d  = READ;
               end
            end
         end
         READ: begin
            suma_d   = suma_q + SUM_W'(Dato_s);
            if (Dato_s > maximo_q) maximo_d = Dato_s;
            dato_e_d = Dato_s + addend_q;
            en_d     = 1'b1;
            state_d  = WRITE;
         end
         WRITE: begin
            if (rem_q > W'(1)) begin
               rem_d   = rem_q - W'(1);
               dir_d   = dir_q + W'(1);
               state_d = READ;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Dir    = dir_q;
   assign Dato_e = dato_e_q;
   assign EN     = en_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign suma   = suma_q;
   assign maximo = maximo_q;

endmodule

// File: tb/tb_ram_sweep_master.sv
// Scoreboard bench for ram_sweep_master with a 12-word combinational-read RAM model.
module tb_ram_sweep_master;
   import ram_pkg::*;

   localparam int unsigned DEPTH = DEPTH_DEF;
   localparam int unsigned W     = W_DEF;
   localparam int unsigned AIW   = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [W-1:0]     base, len, addend;
   logic [W-1:0]     Dir, Dato_e, Dato_s;
   logic             EN, busy, done, err;
   logic [SUM_W-1:0] suma;
   logic [W-1:0]     maximo;

   logic [W-1:0]     ram   [DEPTH];
   logic [W-1:0]     mem_m [DEPTH];
   logic [15:0]      exp_q [$];
   logic [SUM_W-1:0] sum_m;
   logic [W-1:0]     max_m;
   int               n_tests = 0;
   int               n_fail  = 0;
   int               n_wr    = 0;

   ram_sweep_master #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .addend(addend),
      .Dir(Dir), .Dato_e(Dato_e), .EN(EN), .Dato_s(Dato_s), .busy(busy), .done(done),
      .err(err), .suma(suma), .maximo(maximo)
   );

   always #5 clk = ~clk;

   assign Dato_s = (Dir < W'(DEPTH)) ? ram[Dir[AIW-1:0]] : '0;

   always @(posedge clk) begin
      if (EN && (Dir < W'(DEPTH))) ram[Dir[AIW-1:0]] <= Dato_e;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Every write seen on the bus must match the next planned write.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst && EN) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
         chk("wr_range", 32'(Dir < W'(DEPTH)), 32'd1);
         chk("wr_addr_data", 32'({Dir, Dato_e}), 32'(e));
         n_wr++;
      end
   end

   task automatic plan(input logic [W-1:0] b, input int n, input logic [W-1:0] a);
      logic [W-1:0] w;
      int           ad;
      sum_m = '0;
      max_m = '0;
      for (int i = 0; i < n; i++) begin
         ad = int'(b) + i;
         w  = mem_m[ad];
         exp_q.push_back({W'(ad), W'(w + a)});
         sum_m = sum_m + SUM_W'(w);
         if (w > max_m) max_m = w;
         mem_m[ad] = W'(w + a);
      end
   endtask

   task automatic sweep(input logic [W-1:0] b, input logic [W-1:0] l, input logic [W-1:0] a,
                        input bit repulse, output int lat);
      @(negedge clk);
      base = b; len = l; addend = a; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      chk("busy_after_start", 32'(busy), 32'(l != '0));
      while (!done && lat < 200) begin
         if (repulse) start = (lat == 3);
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk("done_seen", 32'(done), 32'd1);
      chk("busy_in_fin", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      int lat;
      int k;
      logic [W-1:0] init_v [DEPTH];
      init_v = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40,
                 8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102};
      for (int i = 0; i < int'(DEPTH); i++) begin
         ram[i]   = init_v[i];
         mem_m[i] = init_v[i];
      end
      rst = 1'b1; start = 1'b0; base = '0; len = '0; addend = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dir", 32'(Dir), 32'd0);
      chk("rst_en", 32'(EN), 32'd0);
      chk("rst_dato_e", 32'(Dato_e), 32'd0);
      chk("rst_flags", 32'({busy, done, err}), 32'd0);
      chk("rst_suma", 32'(suma), 32'd0);
      chk("rst_maximo", 32'(maximo), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Basic sweep of words 0..2
      n_wr = 0;
      plan(8'd0, 3, 8'd5);
      sweep(8'd0, 8'd3, 8'd5, 1'b0, lat);
      chk("t1_latency", 32'(lat), 32'd7);
      chk("t1_suma", 32'(suma), 32'd240);
      chk("t1_maximo", 32'(maximo), 32'd90);
      chk("t1_ram0", 32'(ram[0]), 32'd95);
      chk("t1_ram1", 32'(ram[1]), 32'd85);
      chk("t1_ram2", 32'(ram[2]), 32'd75);
      chk("t1_writes", 32'(n_wr), 32'd3);

      // Top-of-RAM sweep with data wrap
      n_wr = 0;
      plan(8'd9, 3, 8'd200);
      sweep(8'd9, 8'd3, 8'd200, 1'b0, lat);
      chk("t2_latency", 32'(lat), 32'd7);
      chk("t2_suma", 32'(suma), 32'd303);
      chk("t2_maximo", 32'(maximo), 32'd102);
      chk("t2_ram9", 32'(ram[9]), 32'd44);
      chk("t2_ram10", 32'(ram[10]), 32'd45);
      chk("t2_ram11", 32'(ram[11]), 32'd46);

      // Out-of-range request is rejected
      n_wr = 0;
      @(negedge clk);
      base = 8'd10; len = 8'd3; addend = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t3_err_pulse", 32'(err), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("t3_err_once", 32'(err), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t3_writes", 32'(n_wr), 32'd0);
      chk("t3_suma_hold", 32'(suma), 32'd303);
      chk("t3_maximo_hold", 32'(maximo), 32'd102);

      // Zero-length sweep
      n_wr = 0;
      sweep(8'd5, 8'd0, 8'd7, 1'b0, lat);
      chk("t4_latency", 32'(lat), 32'd1);
      chk("t4_writes", 32'(n_wr), 32'd0);
      chk("t4_suma", 32'(suma), 32'd0);
      chk("t4_maximo", 32'(maximo), 32'd0);

      // Start re-pulsed mid-sweep is ignored
      n_wr = 0;
      plan(8'd3, 4, 8'd1);
      sweep(8'd3, 8'd4, 8'd1, 1'b1, lat);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_latency", 32'(lat), 32'd9);
      chk("t5_writes", 32'(n_wr), 32'd4);
      chk("t5_suma", 32'(suma), 32'(sum_m));
      chk("t5_maximo", 32'(maximo), 32'(max_m));
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset during WRITE of the second word
      n_wr = 0;
      plan(8'd0, 1, 8'd1);
      @(negedge clk);
      base = 8'd0; len = 8'd3; addend = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!(EN && Dir == 8'd1) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("t6_in_write2", 32'({EN, Dir}), 32'({1'b1, 8'd1}));
      #1 rst = 1'b1;
      #1;
      chk("t6_en_drop", 32'(EN), 32'd0);
      chk("t6_rst_outs", 32'({Dir, Dato_e, busy, done, err}), 32'd0);
      chk("t6_rst_stats", 32'({suma, maximo}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_writes", 32'(n_wr), 32'd1);
      chk("t6_ram0", 32'(ram[0]), 32'(mem_m[0]));
      chk("t6_ram1", 32'(ram[1]), 32'd85);
      chk("t6_ram2", 32'(ram[2]), 32'd75);
      chk("t6_en_idle", 32'(EN), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
